// File: rtl/modn_tick_counter_if.sv
// Handshake bundle for modn_tick_counter: control/load inputs from the upstream
// prescaler side (master) and count/status outputs from the counter (slave).
interface modn_tick_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             tick_in;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic             tc_out;
    logic             load_err;

    modport master (
        output enable, tick_in, clear, load, load_value, dir,
        input  count, tc_out, load_err
    );

    modport slave (
        input  enable, tick_in, clear, load, load_value, dir,
        output count, tc_out, load_err
    );
endinterface

// File: rtl/modn_tick_counter.sv
// Modulo-N tick counter with clear/load, registered wrap pulse and load-range flag.
// Down counting via dir is built only when MODN_TICK_COUNTER_UPDOWN_EN is defined.
module modn_tick_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input logic               clk,
    input logic               rst,
    modn_tick_counter_if.slave io
);
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("modn_tick_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the range compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

`ifdef MODN_TICK_COUNTER_UPDOWN_EN
    localparam logic UPDOWN_EN = 1'b1;
`else
    localparam logic UPDOWN_EN = 1'b0;
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_out_q, tc_out_d;
    logic             load_err_q, load_err_d;
    logic             down_mode;
    logic             load_in_range;

    assign down_mode     = io.dir & UPDOWN_EN;
    assign load_in_range = ({1'b0, io.load_value} < MOD_EXT);

    always_comb begin
        count_d    = count_q;
        tc_out_d   = 1'b0;
        load_err_d = 1'b0;
        if (io.clear) begin
            count_d = '0;
        end else if (io.load) begin
            if (load_in_range) begin
                count_d = io.load_value;
            end else begin
                count_d    = MAX_CNT;
                load_err_d = 1'b1;
            end
        end else if (io.tick_in && io.enable) begin
            if (down_mode) begin
                if (count_q == '0) begin
                    count_d  = MAX_CNT;
                    tc_out_d = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end else begin
                if (count_q == MAX_CNT) begin
                    count_d  = '0;
                    tc_out_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            tc_out_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_out_q   <= tc_out_d;
            load_err_q <= load_err_d;
        end
    end

    assign io.count    = count_q;
    assign io.tc_out   = tc_out_q;
    assign io.load_err = load_err_q;
endmodule
